// File: rtl/pipe_adder_nb_if.sv
// Valid/ready stream interface for pipe_adder_nb: operand beats in, sum beats out.
// The ovf member exists only when OVF_FLAG_EN is defined.
interface pipe_adder_nb_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipe_adder_nb.sv
// Pipelined WIDTH-bit adder, one CH-bit chunk per stage, carry registered between stages.
// Define OVF_FLAG_EN to add the signed-overflow output bus.ovf.
module pipe_adder_nb #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_adder_nb_if.slave bus
);
  localparam int CH = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
    $error("pipe_adder_nb: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  function automatic logic [CH:0] chunk_add(input logic [CH-1:0] x, input logic [CH-1:0] y,
                                            input logic ci);
    return {1'b0, x} + {1'b0, y} + {{CH{1'b0}}, ci};
  endfunction

  function automatic logic [WIDTH-1:0] place(input logic [CH-1:0] chunk, input int idx);
    logic [WIDTH-1:0] t;
    t          = '0;
    t[CH-1:0]  = chunk;
    return t << (idx * CH);
  endfunction

  logic             stall_s;
  logic             en_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;

  logic             last_vld_s;
  logic [CH-1:0]    last_a_s;
  logic [CH-1:0]    last_b_s;
  logic             last_c_s;
  logic [WIDTH-1:0] last_acc_s;
  logic [CH:0]      last_add_s;

  assign stall_s       = out_valid_r & ~bus.out_ready;
  assign en_s          = ~stall_s;
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;

  if (STAGES == 1) begin : g_single
    assign last_vld_s = bus.in_valid;
    assign last_a_s   = bus.a;
    assign last_b_s   = bus.b;
    assign last_c_s   = bus.c_in;
    assign last_acc_s = '0;
  end else begin : g_multi
    localparam int NI = STAGES - 1;

    // Operand skew regs hold the not-yet-added bits shifted down, so the next chunk is at [CH-1:0].
    logic [NI-1:0]    vld_r;
    logic [NI-1:0]    cy_r;
    logic [WIDTH-1:0] acc_r [NI];
    logic [WIDTH-1:0] opa_r [NI];
    logic [WIDTH-1:0] opb_r [NI];
    logic [CH:0]      add_s [NI];

    // chunk adders for the internal stages
    always_comb begin
      add_s[0] = chunk_add(bus.a[CH-1:0], bus.b[CH-1:0], bus.c_in);
      for (int k = 1; k < NI; k++) begin
        add_s[k] = chunk_add(opa_r[k-1][CH-1:0], opb_r[k-1][CH-1:0], cy_r[k-1]);
      end
    end

    // internal stage registers, all holding together on stall
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= '0;
        cy_r  <= '0;
        for (int k = 0; k < NI; k++) begin
          acc_r[k] <= '0;
          opa_r[k] <= '0;
          opb_r[k] <= '0;
        end
      end else if (en_s) begin
        vld_r[0] <= bus.in_valid;
        cy_r[0]  <= add_s[0][CH];
        acc_r[0] <= place(add_s[0][CH-1:0], 0);
        opa_r[0] <= bus.a >> CH;
        opb_r[0] <= bus.b >> CH;
        for (int k = 1; k < NI; k++) begin
          vld_r[k] <= vld_r[k-1];
          cy_r[k]  <= add_s[k][CH];
          acc_r[k] <= acc_r[k-1] | place(add_s[k][CH-1:0], k);
          opa_r[k] <= opa_r[k-1] >> CH;
          opb_r[k] <= opb_r[k-1] >> CH;
        end
      end
    end

    assign last_vld_s = vld_r[NI-1];
    assign last_a_s   = CH'(opa_r[NI-1]);
    assign last_b_s   = CH'(opb_r[NI-1]);
    assign last_c_s   = cy_r[NI-1];
    assign last_acc_s = acc_r[NI-1];
  end

  // top chunk adder feeding the output register
  always_comb begin
    last_add_s = chunk_add(last_a_s, last_b_s, last_c_s);
  end

  // output register; data only updates on a valid slot so it holds across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= last_vld_s;
      if (last_vld_s) begin
        sum_r   <= last_acc_s | place(last_add_s[CH-1:0], STAGES - 1);
        c_out_r <= last_add_s[CH];
      end
    end
  end

`ifdef OVF_FLAG_EN
  logic ovf_r;

  // signed overflow from the skewed operand MSBs and the top chunk's sum MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (en_s && last_vld_s) begin
      ovf_r <= (last_a_s[CH-1] == last_b_s[CH-1]) && (last_add_s[CH-1] != last_a_s[CH-1]);
    end
  end

  assign bus.ovf = ovf_r;
`endif
endmodule

// File: tb/tb_pipe_adder_nb.sv
// Scoreboard bench for pipe_adder_nb: STAGES=4, 1 and 16 instances share one input stream.
// Define OVF_FLAG_EN to also exercise the overflow flag.
module tb_pipe_adder_nb;
  localparam int W     = 16;
  localparam int N_DUT = 3;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         c_in      = 1'b0;
  logic         out_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   rd[N_DUT];
  int   stg[N_DUT] = '{4, 1, 16};

  always #5 clk = ~clk;

  pipe_adder_nb_if #(.WIDTH(W)) if4  ();
  pipe_adder_nb_if #(.WIDTH(W)) if1  ();
  pipe_adder_nb_if #(.WIDTH(W)) if16 ();

  pipe_adder_nb #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  pipe_adder_nb #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipe_adder_nb #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  assign if4.in_valid   = in_valid;  assign if1.in_valid   = in_valid;  assign if16.in_valid   = in_valid;
  assign if4.a          = a;         assign if1.a          = a;         assign if16.a          = a;
  assign if4.b          = b;         assign if1.b          = b;         assign if16.b          = b;
  assign if4.c_in       = c_in;      assign if1.c_in       = c_in;      assign if16.c_in       = c_in;
  assign if4.out_ready  = out_ready; assign if1.out_ready  = out_ready; assign if16.out_ready  = out_ready;

  logic [N_DUT-1:0] ov_s;
  logic [N_DUT-1:0] ir_s;
  logic [N_DUT-1:0] co_s;
  logic [N_DUT-1:0] ovf_s;
  logic [W-1:0]     sum_s [N_DUT];

  assign ov_s  = {if16.out_valid, if1.out_valid, if4.out_valid};
  assign ir_s  = {if16.in_ready, if1.in_ready, if4.in_ready};
  assign co_s  = {if16.c_out, if1.c_out, if4.c_out};
  assign sum_s[0] = if4.sum;
  assign sum_s[1] = if1.sum;
  assign sum_s[2] = if16.sum;
`ifdef OVF_FLAG_EN
  assign ovf_s = {if16.ovf, if1.ovf, if4.ovf};
`else
  assign ovf_s = '0;
`endif

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum  = t[W-1:0];
    e.cout = t[W];
`ifdef OVF_FLAG_EN
    e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic all_ready();
    return !((|ov_s) && !out_ready);
  endfunction

  function automatic logic all_drained();
    logic d;
    d = 1'b1;
    for (int i = 0; i < N_DUT; i++) if (rd[i] != exp_q.size()) d = 1'b0;
    return d;
  endfunction

  // scoreboard: pop on every output transfer and check in_ready against the stall rule
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_DUT; i++) begin
        exp_t e;
        checks++;
        if (ir_s[i] !== !(ov_s[i] && !out_ready)) begin
          errors++;
          $display("FAIL in_ready stages=%0d: got %b, required %b", stg[i], ir_s[i], !(ov_s[i] && !out_ready));
        end
        if (ov_s[i] && out_ready) begin
          checks++;
          if (rd[i] >= exp_q.size()) begin
            errors++;
            $display("FAIL sb_extra stages=%0d: got sum=%h c_out=%b, required no output", stg[i], sum_s[i], co_s[i]);
          end else begin
            e = exp_q[rd[i]];
            if (sum_s[i] !== e.sum || co_s[i] !== e.cout || ovf_s[i] !== e.ovf) begin
              errors++;
              $display("FAIL sb_data stages=%0d beat=%0d: got sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                       stg[i], rd[i], sum_s[i], co_s[i], ovf_s[i], e.sum, e.cout, e.ovf);
            end
            rd[i]++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc);
    int n;
    n = 0;
    while (!all_ready() && n < 100) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_timeout: pipeline still stalled after %0d cycles, required ready", n);
    end else begin
      a = aa; b = bb; c_in = cc; in_valid = 1'b1;
      exp_q.push_back(model(aa, bb, cc));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!all_drained() && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: delivered %0d/%0d/%0d, required %0d each", rd[0], rd[1], rd[2], exp_q.size());
    end
  endtask

  // one beat into an empty pipe; out_valid must rise exactly STAGES edges after capture
  task automatic single_beat_latency(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                     input logic cc);
    out_ready = 1'b1;
    send(aa, bb, cc);
    for (int e = 1; e <= 17; e++) begin
      for (int i = 0; i < N_DUT; i++) begin
        checks++;
        if (ov_s[i] !== (e == stg[i])) begin
          errors++;
          $display("FAIL %s_latency stages=%0d edge=%0d: out_valid=%b, required %b", name, stg[i], e, ov_s[i], (e == stg[i]));
        end
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (ov_s[i] !== 1'b0 || sum_s[i] !== 16'h0000 || co_s[i] !== 1'b0 || ovf_s[i] !== 1'b0 || ir_s[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset stages=%0d: out_valid=%b sum=%h c_out=%b ovf=%b in_ready=%b, required 0 0000 0 0 1",
                 stg[i], ov_s[i], sum_s[i], co_s[i], ovf_s[i], ir_s[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    single_beat_latency("zero", 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic test_carry_wrap();
    send(16'hFFFF, 16'h0000, 1'b1);
    drain();
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (sum_s[i] !== 16'h0000 || co_s[i] !== 1'b1) begin
        errors++;
        $display("FAIL carry_wrap stages=%0d: sum=%h c_out=%b, required 0000 1", stg[i], sum_s[i], co_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first[N_DUT];
    int cnt[N_DUT];
    for (int i = 0; i < N_DUT; i++) begin first[i] = -1; cnt[i] = 0; end
    out_ready = 1'b1;
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0);
        send(16'h00FF, 16'h0001, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
      end
      begin
        for (int cyc = 0; cyc < 24; cyc++) begin
          @(posedge clk); #1;
          for (int i = 0; i < N_DUT; i++) begin
            if (ov_s[i]) begin
              if (first[i] < 0) first[i] = cyc;
              if (cyc - first[i] < 3) cnt[i]++;
            end
          end
        end
      end
    join
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (cnt[i] !== 3) begin
        errors++;
        $display("FAIL back_to_back stages=%0d: %0d consecutive valid cycles, required 3", stg[i], cnt[i]);
      end
    end
    drain();
  endtask

  task automatic test_stall();
    logic [W-1:0] snap_sum [2];
    logic         snap_co  [2];
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    ta = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFE};
    tb = '{16'h1111, 16'h5432, 16'hF0F1, 16'h0003};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(ta[k], tb[k], k[0]);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin snap_sum[i] = sum_s[i]; snap_co[i] = co_s[i]; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ir_s[i] !== 1'b0 || ov_s[i] !== 1'b1 || sum_s[i] !== snap_sum[i] || co_s[i] !== snap_co[i]) begin
          errors++;
          $display("FAIL stall_hold stages=%0d cyc=%0d: in_ready=%b out_valid=%b sum=%h c_out=%b, required 0 1 %h %b",
                   stg[i], c, ir_s[i], ov_s[i], sum_s[i], co_s[i], snap_sum[i], snap_co[i]);
        end
      end
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(16'h0101, 16'h0202, 1'b0);
    send(16'h0303, 16'h0404, 1'b1);
    send(16'h0505, 16'h0606, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (ov_s[i] !== 1'b0 || sum_s[i] !== 16'h0000 || co_s[i] !== 1'b0 || ir_s[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid stages=%0d: out_valid=%b sum=%h c_out=%b in_ready=%b, required 0 0000 0 1",
                 stg[i], ov_s[i], sum_s[i], co_s[i], ir_s[i]);
      end
      rd[i] = exp_q.size();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    single_beat_latency("post_reset", 16'h4321, 16'h1234, 1'b1);
  endtask

`ifdef OVF_FLAG_EN
  task automatic test_ovf();
    send(16'h7FFF, 16'h0001, 1'b0);
    drain();
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (sum_s[i] !== 16'h8000 || ovf_s[i] !== 1'b1 || co_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL ovf_set stages=%0d: sum=%h ovf=%b c_out=%b, required 8000 1 0", stg[i], sum_s[i], ovf_s[i], co_s[i]);
      end
    end
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();
    for (int i = 0; i < N_DUT; i++) begin
      checks++;
      if (ovf_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL ovf_clear stages=%0d: ovf=%b, required 0", stg[i], ovf_s[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if (k % 7 == 6) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < N_DUT; i++) rd[i] = 0;
    test_reset();
    test_zero();
    test_carry_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef OVF_FLAG_EN
    test_ovf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
